// File: rtl/fetch_decode_buffer.sv
// Elastic {pc, instr} queue between fetch and decode, flushed on redirect.
// Define FDBUF_BYPASS_EN to let an entry pass straight through an empty buffer.
module fetch_decode_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    ptr_t          wr_ptr;
    ptr_t          rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [63:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;
    logic write_en;
    logic read_en;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // The extra pointer MSB separates full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign in_ready = ~full;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        bypass    = 1'b0;
        out_valid = 1'b0;
        out_pc    = '0;
        out_instr = '0;
`ifdef FDBUF_BYPASS_EN
        bypass = empty & in_valid & ~flush;
`endif
        if (!empty) begin
            out_valid = 1'b1;
            out_pc    = pc_mem[rd_idx];
            out_instr = instr_mem[rd_idx];
        end else if (bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end

    // A bypassed entry consumed in the same cycle never touches storage.
    always_comb begin
        push     = in_valid & ~full & ~flush;
        pop      = out_valid & out_ready & ~flush;
        write_en = push & ~(bypass & out_ready);
        read_en  = pop & ~empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(write_en);
            rd_ptr <= rd_ptr + PW'(read_en);
            count  <= count + PW'(write_en) - PW'(read_en);
        end
    end

    // NOTE: storage carries no reset; stale contents are never visible because the outputs are masked while empty.
    always_ff @(posedge clk) begin
        if (write_en) begin
            pc_mem[wr_idx]    <= in_pc;
            instr_mem[wr_idx] <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for fetch_decode_buffer: accepted entries are queued, a monitor pops on each handshake.
module tb_fetch_decode_buffer;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_pc;
    logic [31:0]   in_instr;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_pc;
    logic [31:0]   out_instr;
    logic [CW-1:0] count;

    int n_checks  = 0;
    int n_fail    = 0;
    int rx_count  = 0;
    int max_count = 0;

    logic [95:0] exp_q [$];
    logic [95:0] mon_exp;

    fetch_decode_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Entries accepted by the buffer become expected outputs; flush or reset discards them.
    always @(negedge clk) begin
        if (reset || flush)
            exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back({in_pc, in_instr});
        if (!reset && int'(count) > max_count)
            max_count = int'(count);
    end

    always @(negedge clk) begin
        #1;
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got %h, want no output", {out_pc, out_instr});
            end else begin
                mon_exp = exp_q.pop_front();
                check("scoreboard", {out_pc, out_instr}, mon_exp);
                rx_count++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [63:0] pc, input logic [31:0] ins);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = ins;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready=0 for pc %h, want acceptance", pc);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid && count == '0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got count=%0d out_valid=%0b, want empty", name, count, out_valid);
        end
        step();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_count",     count,     '0);
        check("rst_out_pc",    out_pc,    '0);
        check("rst_out_instr", out_instr, '0);

        // Test 1: single entry, consumer ready
        step();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 64'h0000_0000_8000_0000;
        in_instr  = 32'h00A0_0093;
        @(negedge clk);
`ifdef FDBUF_BYPASS_EN
        check("t1_bypass_valid", out_valid, 1'b1);
        check("t1_bypass_count", count, '0);
`else
        check("t1_latency", out_valid, 1'b0);
`endif
        step();
        in_valid = 1'b0;
        @(negedge clk);
`ifdef FDBUF_BYPASS_EN
        check("t1_valid_after", out_valid, 1'b0);
        check("t1_count_after", count, '0);
`else
        check("t1_valid_after", out_valid, 1'b1);
        check("t1_count_after", count, 2'd1);
`endif
        step();
        @(negedge clk);
        check("t1_empty_valid", out_valid, 1'b0);
        check("t1_empty_count", count, '0);
        check("t1_empty_pc",    out_pc, '0);
        check("t1_rx",          rx_count, 1);

        // Test 2: fill with consumer stalled, third entry held off
        step();
        out_ready = 1'b0;
        push_entry(64'h1000, 32'h0000_0113);
        push_entry(64'h1004, 32'h0000_0193);
        in_valid = 1'b1;
        in_pc    = 64'h1008;
        in_instr = 32'h0000_0213;
        @(negedge clk);
        check("t2_full_ready", in_ready, 1'b0);
        check("t2_full_count", count, 2'd2);
        check("t2_head_valid", out_valid, 1'b1);
        check("t2_head_pc",    out_pc, 64'h1000);
        check("t2_head_instr", out_instr, 32'h0000_0113);
        step();
        @(negedge clk);
        check("t2_stall_pc",    out_pc, 64'h1000);
        check("t2_stall_ready", in_ready, 1'b0);

        // Test 3: pop while full refuses the push; third accepted next cycle
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_push_refused", in_ready, 1'b0);
        step();
        @(negedge clk);
        check("t3_ready_again", in_ready, 1'b1);
        check("t3_count",       count, 2'd1);
        check("t3_head_pc",     out_pc, 64'h1004);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_count_pp", count, 2'd1);
        check("t3_last_pc",  out_pc, 64'h1008);
        step();
        @(negedge clk);
        check("t3_drained", count, '0);
        check("t3_rx",      rx_count, 4);

        // Test 4: stream ten entries with alternating consumer
        step();
        max_count = 0;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    push_entry(64'h2000 + 64'(4 * i), 32'h13 | (32'(i) << 7));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = c[0];
                    step();
                end
            end
        join
        drain("t4_drain_timeout");
        check("t4_rx",        rx_count, 14);
        check("t4_max_count", max_count <= 2, 1'b1);

        // Test 5: flush with two entries held and a push offered
        out_ready = 1'b0;
        push_entry(64'h3000, 32'h0000_0313);
        push_entry(64'h3004, 32'h0000_0393);
        in_valid = 1'b1;
        in_pc    = 64'h3008;
        in_instr = 32'h0000_0413;
        flush    = 1'b1;
        @(negedge clk);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_valid", out_valid, 1'b0);
        check("t5_count", count, '0);
        check("t5_ready", in_ready, 1'b1);
        check("t5_pc",    out_pc, '0);
        step();
        out_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("t5_dropped", rx_count, 14);

        // Test 6: asynchronous reset between clock edges
        step();
        out_ready = 1'b0;
        push_entry(64'h4000, 32'h0000_0493);
        push_entry(64'h4004, 32'h0000_0513);
        #2;
        reset = 1'b1;
        #1;
        check("t6_valid", out_valid, 1'b0);
        check("t6_count", count, '0);
        check("t6_ready", in_ready, 1'b1);
        check("t6_pc",    out_pc, '0);
        @(negedge clk);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        push_entry(64'h5000, 32'h0000_0593);
        drain("t6_drain_timeout");
        check("t6_rx",       rx_count, 15);
        check("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
